mmio_pwm_bank: RTL and testbench

Memory-mapped, parametrised PWM peripheral on the multi-cycle processor's data bus, driving the board LED and RGB pins. Generalises the fixed LED/RGB outputs to NUM_CH independent channels of PWM_W-bit duty, with a shared programmable prescaler, per-channel static/fade/breathe modes, output inversion and glitch-free duty updates. Sits beside data memory in the processor's address decode; its `pwm_out` bits go to the top-level LED/RGB ports.

---
 rtl/mmio_pwm_bank_if.sv | 20 ++
 rtl/mmio_pwm_bank.sv | 171 +++++++++++++++++
 tb/tb_mmio_pwm_bank.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pwm_bank_if.sv
// Data-bus port of the PWM bank.
// Word strobes in, registered read data back.
interface mmio_pwm_bank_if;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );
endinterface

// File: rtl/mmio_pwm_bank.sv
// Memory-mapped PWM bank: shared prescaler, per-channel
// static/fade/breathe duty with wrap-aligned shadow update.
module mmio_pwm_bank #(
    parameter int NUM_CH = 4,
    parameter int PWM_W  = 8,
    parameter int PRE_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_pwm_bank_if.slave    bus,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam logic [PWM_W-1:0] C_LAST = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [1:0] M_FADE    = 2'b01;
    localparam logic [1:0] M_BREATHE = 2'b10;

    logic              en, inv, en_n, inv_n;
    logic [PRE_W-1:0]  pre, p;
    logic [PWM_W-1:0]  c;
    logic              tick, wrap;
    logic [31:0]       widx;
    logic              wr_ctrl, wr_pre;
    logic [NUM_CH-1:0] wr_duty;
    logic [PWM_W-1:0]  tgt   [NUM_CH];
    logic [PWM_W-1:0]  tgt_n [NUM_CH];
    logic [PWM_W-1:0]  cur   [NUM_CH];
    logic [PWM_W-1:0]  cur_n [NUM_CH];
    logic [PWM_W-1:0]  s     [NUM_CH];
    logic [1:0]        mode  [NUM_CH];
    logic [1:0]        mode_n[NUM_CH];
    logic [NUM_CH-1:0] dir, dir_n;
    logic [NUM_CH-1:0] done, done_n;
    logic [NUM_CH-1:0] raw;
    logic [31:0]       rd_mux;

    assign widx    = {28'd0, bus.addr[5:2]};
    assign wr_ctrl = bus.we && (widx == 32'd0);
    assign wr_pre  = bus.we && (widx == 32'd1);
    assign en_n    = wr_ctrl ? bus.wdata[0] : en;
    assign inv_n   = wr_ctrl ? bus.wdata[1] : inv;
    assign tick    = en && (p == pre);
    assign wrap    = tick && (c == C_LAST);

    // Per-channel write decode and raw compare against the shadow duty.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = bus.we && (widx == 32'(4 + i));
            raw[i]     = (c < s[i]);
        end
    end

    // Next target/mode/ramp state; a write wins for target and mode.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_n[i]  = wr_duty[i] ? bus.wdata[PWM_W-1:0] : tgt[i];
            mode_n[i] = wr_duty[i] ? bus.wdata[17:16] : mode[i];
            cur_n[i]  = cur[i];
            dir_n[i]  = wr_duty[i] ? 1'b0 : dir[i];
            done_n[i] = wr_duty[i] ? 1'b0 : done[i];
            unique case (1'b1)
                mode_n[i] == M_FADE: begin
                    if (!en) begin
                        cur_n[i]  = '0;
                        done_n[i] = 1'b0;
                    end else if (wrap) begin
                        if (cur[i] < tgt_n[i])
                            cur_n[i] = cur[i] + 1'b1;
                        else if (cur[i] > tgt_n[i])
                            cur_n[i] = cur[i] - 1'b1;
                        done_n[i] = (cur_n[i] == tgt_n[i]);
                    end
                end
                mode_n[i] == M_BREATHE: begin
                    done_n[i] = 1'b0;
                    if (!en) begin
                        cur_n[i] = '0;
                        dir_n[i] = 1'b0;
                    end else if (wrap) begin
                        if (!dir_n[i]) begin
                            if (cur[i] < tgt_n[i]) begin
                                cur_n[i] = cur[i] + 1'b1;
                            end else begin
                                dir_n[i] = 1'b1;
                                cur_n[i] = (cur[i] == '0) ? '0 : cur[i] - 1'b1;
                            end
                        end else if (cur[i] != '0) begin
                            cur_n[i] = cur[i] - 1'b1;
                        end else begin
                            dir_n[i] = 1'b0;
                            cur_n[i] = (tgt_n[i] == '0) ? '0 : PWM_W'(1);
                        end
                    end
                end
                default: begin
                    cur_n[i] = tgt_n[i];
                    if (wr_duty[i])
                        done_n[i] = 1'b1;
                end
            endcase
        end
    end

    // Read mux over the register map; unmapped words read 0.
    always_comb begin
        rd_mux = '0;
        if (widx == 32'd0) begin
            rd_mux[1:0] = {inv, en};
        end else if (widx == 32'd1) begin
            rd_mux[PRE_W-1:0] = pre;
        end else if (widx == 32'd2) begin
            rd_mux[PWM_W-1:0]   = c;
            rd_mux[16+:NUM_CH]  = done;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (widx == 32'(4 + i)) begin
                rd_mux[PWM_W-1:0] = tgt[i];
                rd_mux[17:16]     = mode[i];
            end
            if (widx == 32'(4 + NUM_CH + i))
                rd_mux[PWM_W-1:0] = cur[i];
        end
    end

    // Registers, timebase, channel state, outputs and read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            inv        <= 1'b0;
            pre        <= '0;
            p          <= '0;
            c          <= '0;
            dir        <= '0;
            done       <= '0;
            pwm_out    <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i]  <= '0;
                mode[i] <= '0;
                cur[i]  <= '0;
                s[i]    <= '0;
            end
        end else begin
            en  <= en_n;
            inv <= inv_n;
            if (wr_pre)
                pre <= bus.wdata[PRE_W-1:0];
            if (!en || tick)
                p <= '0;
            else
                p <= p + 1'b1;
            if (!en || wrap)
                c <= '0;
            else if (tick)
                c <= c + 1'b1;
            dir  <= dir_n;
            done <= done_n;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i]  <= tgt_n[i];
                mode[i] <= mode_n[i];
                cur[i]  <= cur_n[i];
                if (!en || wrap)
                    s[i] <= cur[i];
            end
            pwm_out <= en_n ? (raw ^ {NUM_CH{inv_n}}) : {NUM_CH{inv_n}};
            bus.rvalid <= bus.re;
            if (bus.re)
                bus.rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_mmio_pwm_bank.sv
// Scoreboard bench for mmio_pwm_bank: bus reads checked by a
// monitor; PWM waveforms counted against hand-computed duties.
module tb_mmio_pwm_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pwm_out;

    mmio_pwm_bank_if bus();

    mmio_pwm_bank #(.NUM_CH(4), .PWM_W(8), .PRE_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        string       n;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Pop one expectation per returned read.
    always @(negedge clk) begin
        if (rst_n && bus.rvalid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: got 1 expected 0");
            end else begin
                e = q.pop_front();
                check(e.n, bus.rdata & e.m, e.d & e.m);
            end
        end
    end

    task automatic wr(logic [5:0] a, logic [31:0] d);
        @(posedge clk);
        #1;
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(logic [5:0] a, logic [31:0] d, logic [31:0] m, string n);
        @(posedge clk);
        #1;
        bus.addr = a;
        bus.re   = 1'b1;
        q.push_back('{d, m, n});
        @(posedge clk);
        #1;
        bus.re = 1'b0;
    endtask

    task automatic wrd(logic [5:0] a, logic [31:0] wd, logic [31:0] d, string n);
        @(posedge clk);
        #1;
        bus.addr  = a;
        bus.wdata = wd;
        bus.we    = 1'b1;
        bus.re    = 1'b1;
        q.push_back('{d, 32'hFFFF_FFFF, n});
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    // Wait for the period-start pulse of ch3 (static duty 1).
    task automatic sync(string n);
        int k = 0;
        @(negedge clk);
        while (pwm_out[3] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        while (!pwm_out[3] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got none expected pwm_out[3] rise", n);
        end
    endtask

    task automatic count_hi(int ch, output int hc);
        hc = 0;
        for (int i = 0; i < 255; i++) begin
            if (pwm_out[ch])
                hc++;
            @(negedge clk);
        end
    endtask

    logic [7:0] fade_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [7:0] br_exp   [7] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    localparam logic [31:0] FULL = 32'hFFFF_FFFF;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, h3, hc;
        rst_n     = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        rst_n = 1'b1;
        rd(6'h00, 32'h0, FULL, "rst_ctrl");
        rd(6'h04, 32'h0, FULL, "rst_pre");
        rd(6'h08, 32'h0, FULL, "rst_status");
        rd(6'h10, 32'h0, FULL, "rst_duty0");
        rd(6'h24, 32'h0, FULL, "rst_cur1");

        wr(6'h10, 32'd64);
        wr(6'h14, 32'd0);
        wr(6'h18, 32'd255);
        wr(6'h1C, 32'd1);
        rd(6'h10, 32'd64, FULL, "duty0_rb");
        rd(6'h20, 32'd64, FULL, "cur0_static");
        wr(6'h00, 32'h1);
        sync("static");
        h0 = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 255; i++) begin
            if (pwm_out[0]) h0++;
            if (pwm_out[1]) h1++;
            if (pwm_out[2]) h2++;
            if (pwm_out[3]) h3++;
            @(negedge clk);
        end
        check("static_64", h0, 64);
        check("static_0", h1, 0);
        check("static_255", h2, 255);
        check("static_1", h3, 1);

        wr(6'h14, 32'd200);
        sync("glitch");
        fork
            count_hi(1, hc);
            begin
                repeat (50) @(posedge clk);
                wr(6'h14, 32'd10);
            end
        join
        check("glitch_old_period", hc, 200);
        count_hi(1, hc);
        check("glitch_new_period", hc, 10);

        wr(6'h18, 32'd0);
        wr(6'h18, 32'h0001_0005);
        for (int k = 0; k < 5; k++) begin
            sync("fade");
            rd(6'h28, 32'(fade_exp[k]), FULL, "fade_cur");
            if (k == 3)
                rd(6'h08, 32'h000B_0000, 32'h000F_0000, "fade_not_done");
        end
        rd(6'h08, 32'h000F_0000, 32'h000F_0000, "fade_done");
        sync("fade_hold");
        rd(6'h28, 32'd5, FULL, "fade_hold_cur");
        rd(6'h08, 32'h000F_0000, 32'h000F_0000, "fade_done_hold");

        wr(6'h10, 32'd0);
        wr(6'h10, 32'h0002_0003);
        for (int k = 0; k < 7; k++) begin
            sync("breathe");
            rd(6'h20, 32'(br_exp[k]), FULL, "breathe_cur");
            if (k == 2 || k == 5)
                rd(6'h08, 32'h0, 32'h0001_0000, "breathe_done0");
        end

        rd(6'h3C, 32'h0, FULL, "unmapped");
        wrd(6'h14, 32'd77, 32'd10, "rw_same_old");
        rd(6'h14, 32'd77, FULL, "rw_same_new");
        wr(6'h28, 32'hFF);
        rd(6'h28, 32'd5, FULL, "ro_ignored");
        wr(6'h04, 32'd2);
        rd(6'h04, 32'd2, FULL, "pre_rb");
        sync("prescale");
        hc = 0;
        while (pwm_out[3] && hc < 10) begin
            hc++;
            @(negedge clk);
        end
        check("prescale_3", hc, 3);

        wr(6'h00, 32'h2);
        @(negedge clk);
        check("inv_en0", 32'(pwm_out), 32'hF);
        rd(6'h08, 32'h0, 32'h0000_FFFF, "en0_counter");
        wr(6'h00, 32'h0);
        @(negedge clk);
        check("inv0_en0", 32'(pwm_out), 32'h0);

        wr(6'h00, 32'h1);
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_pwm", 32'(pwm_out), 32'h0);
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_rvalid", 32'(bus.rvalid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(6'h08, 32'h0, FULL, "midrst_status");
        rd(6'h00, 32'h0, FULL, "midrst_ctrl");
        rd(6'h10, 32'h0, FULL, "midrst_duty0");

        repeat (4) @(negedge clk);
        check("pending_reads", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
